// File: rtl/config_pkg.sv
// Shared constants and types for the ALU packet parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package config_pkg;

  // Opcodes the downstream ALU/echo datapath understands
  localparam logic [7:0] OP_ECHO  = 8'hEC;
  localparam logic [7:0] OP_ADD32 = 8'hA0;
  localparam logic [7:0] OP_MUL32 = 8'hA1;
  localparam logic [7:0] OP_DIV32 = 8'hA2;

  // Header is opcode, reserved, length LSB, length MSB
  localparam int HDR_BYTES = 4;

  // Parser FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RSVD    = 3'd1,
    LEN_LO  = 3'd2,
    LEN_HI  = 3'd3,
    PAYLOAD = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  // True when the opcode is one the datapath can execute
  function automatic logic is_known_op(input logic [7:0] op);
    logic known;
    case (op)
      OP_ECHO, OP_ADD32, OP_MUL32, OP_DIV32: known = 1'b1;
      default:                               known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/alu_packet_parser.sv
// Splits a UART byte stream into header fields and a payload stream.
// Latency: header fields/pulse one cycle after the length MSB; payload passes through with zero latency.
// Backpressure: payload_ready_i low stalls rx_ready_o in PAYLOAD; header and drain bytes are always accepted.
module alu_packet_parser
  import config_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  opcode_o,
  output logic [15:0] len_o,
  output logic        hdr_valid_o,
  output logic [7:0]  payload_data_o,
  output logic        payload_valid_o,
  input  logic        payload_ready_i,
  output logic        payload_last_o,
  output logic        err_o,
  output logic        busy_o
);

  // Counter wide enough to hold TIMEOUT_CYCLES itself
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The timeout fires on the edge that would take the count to TIMEOUT_CYCLES,
  // i.e. TIMEOUT_CYCLES edges after the last consumed byte.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      HDR_LEN  = 16'(HDR_BYTES);

  state_t           state_q;
  logic [7:0]       op_hold_q;     // opcode captured in IDLE, published at the header decision
  logic [7:0]       len_lo_q;      // length LSB waiting for its MSB
  logic [7:0]       opcode_q;
  logic [15:0]      len_q;
  logic [15:0]      remaining_q;   // payload/drain bytes still owed by the open packet
  logic [CNT_W-1:0] idle_cnt_q;
  logic             hdr_valid_q;
  logic             err_q;

  logic             byte_fire;
  logic [15:0]      hdr_len_d;
  logic [15:0]      hdr_rem_d;
  logic             hdr_short_d;
  logic             hdr_known_d;
  logic             stalled_d;

  // Only PAYLOAD forwards downstream backpressure; every other state sinks bytes freely
  assign rx_ready_o  = (state_q == PAYLOAD) ? payload_ready_i : 1'b1;
  assign byte_fire   = rx_valid_i && rx_ready_o;

  // Header decision inputs, valid while the length MSB is on rx_data_i
  assign hdr_len_d   = {rx_data_i, len_lo_q};
  assign hdr_short_d = (hdr_len_d < HDR_LEN);
  assign hdr_rem_d   = hdr_short_d ? 16'd0 : (hdr_len_d - HDR_LEN);
  assign hdr_known_d = is_known_op(op_hold_q);

  // A payload stall is the consumer's fault, not the sender's, so it does not age the packet
  assign stalled_d   = (state_q == PAYLOAD) && !payload_ready_i;

  // Payload is a straight pass-through of the receive stream while in PAYLOAD
  assign payload_data_o  = rx_data_i;
  assign payload_valid_o = (state_q == PAYLOAD) && rx_valid_i;
  assign payload_last_o  = (state_q == PAYLOAD) && (remaining_q == 16'd1);

  assign opcode_o    = opcode_q;
  assign len_o       = len_q;
  assign hdr_valid_o = hdr_valid_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != IDLE);

  // Parser FSM, header registers, remaining-byte counter and inter-byte timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_hold_q   <= 8'h00;
      len_lo_q    <= 8'h00;
      opcode_q    <= 8'h00;
      len_q       <= 16'h0000;
      remaining_q <= 16'h0000;
      idle_cnt_q  <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;

      if (byte_fire) begin
        // A byte arriving on the timeout edge wins: it is consumed and the count restarts
        idle_cnt_q <= '0;
        case (state_q)
          IDLE: begin
            op_hold_q <= rx_data_i;
            state_q   <= RSVD;
          end
          RSVD: begin
            state_q <= LEN_LO;
          end
          LEN_LO: begin
            len_lo_q <= rx_data_i;
            state_q  <= LEN_HI;
          end
          LEN_HI: begin
            opcode_q <= op_hold_q;
            len_q    <= hdr_len_d;
            if (hdr_short_d) begin
              // Length cannot even cover the header: resync on the next byte
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else if (hdr_known_d) begin
              hdr_valid_q <= 1'b1;
              remaining_q <= hdr_rem_d;
              state_q     <= (hdr_rem_d == 16'd0) ? IDLE : PAYLOAD;
            end else begin
              // Unknown opcode: flag it, but keep framing by swallowing its payload
              err_q       <= 1'b1;
              remaining_q <= hdr_rem_d;
              state_q     <= (hdr_rem_d == 16'd0) ? IDLE : DRAIN;
            end
          end
          PAYLOAD, DRAIN: begin
            if (remaining_q <= 16'd1) begin
              remaining_q <= 16'd0;
              state_q     <= IDLE;
            end else begin
              remaining_q <= remaining_q - 16'd1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end else if (state_q != IDLE) begin
        if (stalled_d) begin
          idle_cnt_q <= '0;
        end else if (idle_cnt_q == CNT_LAST) begin
          // Sender went quiet mid-packet: abandon it without a last beat
          err_q       <= 1'b1;
          state_q     <= IDLE;
          remaining_q <= 16'd0;
          idle_cnt_q  <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_packet_parser.sv
// Directed bench for alu_packet_parser with a short inter-byte timeout.
// Latency: n/a.
// Backpressure: payload_ready_i is driven by the stimulus sequence.
module tb_alu_packet_parser;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  opcode;
  logic [15:0] len;
  logic        hdr_valid;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready = 1'b1;
  logic        pl_last;
  logic        err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // Monitor state (written only by the monitor process)
  int          hdr_cnt = 0;
  int          err_cnt = 0;
  int          beat_cnt = 0;
  int          pv_cnt = 0;
  logic [7:0]  last_op = 8'h00;
  logic [15:0] last_len = 16'h0000;
  logic [8:0]  pq[$];

  // Snapshots taken by the stimulus process
  int h0, e0, b0, p0, q0;

  alu_packet_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .opcode_o       (opcode),
    .len_o          (len),
    .hdr_valid_o    (hdr_valid),
    .payload_data_o (pl_data),
    .payload_valid_o(pl_valid),
    .payload_ready_i(pl_ready),
    .payload_last_o (pl_last),
    .err_o          (err),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Record pulses and payload handshakes as they happen at each rising edge
  always @(posedge clk) begin
    if (hdr_valid) begin
      hdr_cnt  = hdr_cnt + 1;
      last_op  = opcode;
      last_len = len;
    end
    if (err) err_cnt = err_cnt + 1;
    if (pl_valid) pv_cnt = pv_cnt + 1;
    if (pl_valid && pl_ready) begin
      beat_cnt = beat_cnt + 1;
      pq.push_back({pl_last, pl_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    h0 = hdr_cnt; e0 = err_cnt; b0 = beat_cnt; p0 = pv_cnt; q0 = pq.size();
  endtask

  function automatic logic [31:0] pq_at(input int idx);
    if (idx < pq.size()) return {23'd0, pq[idx]};
    return 32'hDEAD;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("send_ready_stuck", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] l);
    send_byte(op);
    send_byte(8'h00);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
  endtask

  task automatic send_echo6();
    send_hdr(8'hEC, 16'd6);
    send_byte(8'h48);
    send_byte(8'h69);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",     {31'd0, busy},      32'd0);
    check("rst_rdy",      {31'd0, rx_ready},  32'd1);
    check("rst_hdr",      {31'd0, hdr_valid}, 32'd0);
    check("rst_err",      {31'd0, err},       32'd0);
    check("rst_opcode",   {24'd0, opcode},    32'd0);
    check("rst_len",      {16'd0, len},       32'd0);
    check("rst_plvalid",  {31'd0, pl_valid},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic echo packet
    snap();
    send_echo6();
    idle(2);
    check("t1_hdr_cnt", hdr_cnt - h0, 1);
    check("t1_opcode",  {24'd0, last_op}, 32'h00EC);
    check("t1_len",     {16'd0, last_len}, 32'h0006);
    check("t1_beats",   beat_cnt - b0, 2);
    check("t1_beat0",   pq_at(q0), 32'h048);
    check("t1_beat1",   pq_at(q0 + 1), 32'h169);
    check("t1_err",     err_cnt - e0, 0);
    check("t1_busy",    {31'd0, busy}, 32'd0);

    // Two packets back to back
    snap();
    send_echo6();
    send_echo6();
    idle(2);
    check("t2_hdr_cnt", hdr_cnt - h0, 2);
    check("t2_beats",   beat_cnt - b0, 4);
    check("t2_beat2",   pq_at(q0 + 2), 32'h048);
    check("t2_beat3",   pq_at(q0 + 3), 32'h169);
    check("t2_err",     err_cnt - e0, 0);

    // Header-only packet, then a too-short length
    snap();
    send_hdr(8'hEC, 16'd4);
    idle(2);
    check("t3_hdr_cnt", hdr_cnt - h0, 1);
    check("t3_len",     {16'd0, last_len}, 32'h0004);
    check("t3_beats",   beat_cnt - b0, 0);
    check("t3_busy",    {31'd0, busy}, 32'd0);
    snap();
    send_hdr(8'hEC, 16'd3);
    idle(2);
    check("t3s_err",    err_cnt - e0, 1);
    check("t3s_hdr",    hdr_cnt - h0, 0);
    check("t3s_busy",   {31'd0, busy}, 32'd0);
    check("t3s_len",    {16'd0, len}, 32'h0003);

    // Unknown opcode is drained, then a good packet parses
    snap();
    send_hdr(8'h77, 16'd6);
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(2);
    check("t4_err",     err_cnt - e0, 1);
    check("t4_hdr",     hdr_cnt - h0, 0);
    check("t4_pvalid",  pv_cnt - p0, 0);
    check("t4_busy",    {31'd0, busy}, 32'd0);
    snap();
    send_echo6();
    idle(2);
    check("t4b_hdr",    hdr_cnt - h0, 1);
    check("t4b_op",     {24'd0, last_op}, 32'h00EC);
    check("t4b_beats",  beat_cnt - b0, 2);
    check("t4b_beat1",  pq_at(q0 + 1), 32'h169);

    // Payload stall longer than the timeout must not lose the byte or time out
    snap();
    send_hdr(8'hEC, 16'd6);
    @(negedge clk);
    pl_ready = 1'b0;
    rx_data  = 8'h48;
    rx_valid = 1'b1;
    repeat (60) @(negedge clk);
    check("t5_rdy_low",   {31'd0, rx_ready}, 32'd0);
    check("t5_pv_zerolat", {31'd0, pl_valid}, 32'd1);
    check("t5_no_beat",   beat_cnt - b0, 0);
    check("t5_no_to",     err_cnt - e0, 0);
    check("t5_busy",      {31'd0, busy}, 32'd1);
    pl_ready = 1'b1;
    @(posedge clk);
    send_byte(8'h69);
    idle(2);
    check("t5_beats",   beat_cnt - b0, 2);
    check("t5_beat0",   pq_at(q0), 32'h048);
    check("t5_beat1",   pq_at(q0 + 1), 32'h169);
    check("t5_err",     err_cnt - e0, 0);

    // Sender stops after first payload byte: err exactly TO edges later
    snap();
    send_hdr(8'hEC, 16'd6);
    send_byte(8'h48);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (TO - 1) @(posedge clk);
    #1;
    check("t6_no_err_early", {31'd0, err},  32'd0);
    check("t6_busy_early",   {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("t6_err_fire",     {31'd0, err},  32'd1);
    check("t6_idle",         {31'd0, busy}, 32'd0);
    idle(2);
    check("t6_err_cnt",      err_cnt - e0, 1);
    check("t6_beats",        beat_cnt - b0, 1);
    check("t6_no_last",      pq_at(q0), 32'h048);

    // Byte landing on the timeout edge is consumed and suppresses the timeout
    snap();
    send_hdr(8'hEC, 16'd6);
    send_byte(8'h48);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h69);
    idle(2);
    check("t7_err",     err_cnt - e0, 0);
    check("t7_beats",   beat_cnt - b0, 2);
    check("t7_last",    pq_at(q0 + 1), 32'h169);

    // Reset mid-header discards the partial packet
    snap();
    send_byte(8'hEC);
    send_byte(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("t8_rst_busy",   {31'd0, busy},   32'd0);
    check("t8_rst_opcode", {24'd0, opcode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    send_echo6();
    idle(2);
    check("t8_hdr",     hdr_cnt - h0, 1);
    check("t8_len",     {16'd0, last_len}, 32'h0006);
    check("t8_beats",   beat_cnt - b0, 2);
    check("t8_err",     err_cnt - e0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if the sequence ever wedges
  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
